// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDRAM power-up init sequencer with periodic auto-refresh requester
// Every output is registered from the next-state decode; commands appear on the edge that enters them.
module sdram_init_seq #(
  parameter int          CLK_FREQ_MHZ = 100,
  parameter int          T_POWERUP_US = 200,
  parameter int          T_RP         = 2,
  parameter int          T_RFC        = 7,
  parameter int          T_MRD        = 2,
  parameter int          T_REFI       = 780,
  parameter logic [12:0] MODE_REG     = 13'h0030
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [12:0] addr,
  output logic [1:0]  ba,
  output logic        init_done,
  output logic        ref_req,
  input  logic        ref_gnt,
  output logic        ref_busy
);

  localparam int P    = T_POWERUP_US * CLK_FREQ_MHZ;
  localparam int MX1  = (P > T_RFC) ? P : T_RFC;
  localparam int MX2  = (MX1 > T_RP) ? MX1 : T_RP;
  localparam int MXC  = (MX2 > T_MRD) ? MX2 : T_MRD;
  localparam int CW   = $clog2(MXC + 1);
  localparam int RW   = $clog2(T_REFI + 1);

  localparam logic [CW-1:0] C_P    = CW'(P);
  localparam logic [CW-1:0] C_RP   = CW'(T_RP);
  localparam logic [CW-1:0] C_RFC  = CW'(T_RFC);
  localparam logic [CW-1:0] C_MRD  = CW'(T_MRD);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [RW-1:0] C_REFI = RW'(T_REFI);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  localparam logic [3:0] CMD_INH = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  typedef enum logic [3:0] {
    WAIT_PU, PRE, WAIT_RP, REF1, WAIT_RFC1, REF2, WAIT_RFC2,
    LMR, WAIT_MRD, READY, REF_PEND, REF_RUN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [RW-1:0] r_refi;
  logic [RW-1:0] w_refi_nx;
  logic [RW-1:0] w_refi_inc;
  logic [3:0]    r_cmd;
  logic [3:0]    w_cmd_nx;
  logic [12:0]   r_addr;
  logic [12:0]   w_addr_nx;
  logic [1:0]    r_ba;
  logic          r_cke;
  logic          r_init_done;
  logic          r_ref_req;
  logic          r_ref_busy;

  // Refresh-interval count saturates so a long-pending request cannot wrap it.
  assign w_refi_inc = (r_refi >= C_REFI) ? C_REFI : r_refi + R_ONE;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + C_ONE;
    w_refi_nx  = r_refi;
    w_cmd_nx   = CMD_NOP;
    w_addr_nx  = '0;
    case (r_state)
      WAIT_PU:             if (r_cnt == C_P) w_state_nx = PRE;
      PRE, WAIT_RP:        w_state_nx = (r_cnt >= C_RP)  ? REF1  : WAIT_RP;
      REF1, WAIT_RFC1:     w_state_nx = (r_cnt >= C_RFC) ? REF2  : WAIT_RFC1;
      REF2, WAIT_RFC2:     w_state_nx = (r_cnt >= C_RFC) ? LMR   : WAIT_RFC2;
      LMR, WAIT_MRD: begin
        w_state_nx = (r_cnt >= C_MRD) ? READY : WAIT_MRD;
        if (r_cnt >= C_MRD) w_refi_nx = '0;
      end
      READY: begin
        w_cnt_nx  = '0;
        w_refi_nx = w_refi_inc;
        if (w_refi_inc >= C_REFI) w_state_nx = REF_PEND;
      end
      REF_PEND: begin
        w_cnt_nx = '0;
        if (ref_gnt) begin
          w_state_nx = REF_RUN;
          w_refi_nx  = '0;
        end
      end
      REF_RUN: begin
        w_refi_nx = w_refi_inc;
        if (r_cnt >= C_RFC) w_state_nx = READY;
      end
      default: w_state_nx = WAIT_PU;
    endcase

    // A command is issued only on the edge that enters its state.
    if (w_state_nx != r_state) begin
      case (w_state_nx)
        PRE: begin
          w_cmd_nx      = CMD_PRE;
          w_addr_nx[10] = 1'b1;
          w_cnt_nx      = C_ONE;
        end
        REF1, REF2, REF_RUN: begin
          w_cmd_nx = CMD_REF;
          w_cnt_nx = C_ONE;
        end
        LMR: begin
          w_cmd_nx  = CMD_LMR;
          w_addr_nx = MODE_REG;
          w_cnt_nx  = C_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= WAIT_PU;
      r_cnt       <= '0;
      r_refi      <= '0;
      r_cke       <= 1'b0;
      r_cmd       <= CMD_INH;
      r_addr      <= '0;
      r_ba        <= '0;
      r_init_done <= 1'b0;
      r_ref_req   <= 1'b0;
      r_ref_busy  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_refi      <= w_refi_nx;
      r_cke       <= 1'b1;
      r_cmd       <= w_cmd_nx;
      r_addr      <= w_addr_nx;
      r_ba        <= '0;
      r_init_done <= r_init_done | (w_state_nx == READY);
      r_ref_req   <= (w_state_nx == REF_PEND);
      r_ref_busy  <= (w_state_nx == REF_RUN);
    end
  end

  assign cke                      = r_cke;
  assign {cs_n, ras_n, cas_n, we_n} = r_cmd;
  assign addr                     = r_addr;
  assign ba                       = r_ba;
  assign init_done                = r_init_done;
  assign ref_req                  = r_ref_req;
  assign ref_busy                 = r_ref_busy;

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb/tb_sdram_init_seq.sv - directed table-driven bench for sdram_init_seq
// Instance 0 runs defaults; instance 1 uses the shortened power-up/refresh parameters.
module tb_sdram_init_seq;

  localparam logic [3:0] INH = 4'b1111;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  typedef struct {
    int         cyc;
    logic [3:0] cmd;
    logic [12:0] addr;
  } ev_t;

  typedef struct {
    int         cyc;
    logic       req;
    logic       busy;
    logic [3:0] cmd;
  } rf_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rstn = 2'b00;
  logic [1:0]       gnt  = 2'b00;
  logic [1:0]       cke, csn, rasn, casn, wen, done, req, busy;
  logic [1:0][12:0] addr;
  logic [1:0][1:0]  ba;

  int checks   = 0;
  int failures = 0;

  sdram_init_seq u_dut0 (
    .clk(clk), .rst_n(rstn[0]), .cke(cke[0]), .cs_n(csn[0]), .ras_n(rasn[0]),
    .cas_n(casn[0]), .we_n(wen[0]), .addr(addr[0]), .ba(ba[0]),
    .init_done(done[0]), .ref_req(req[0]), .ref_gnt(gnt[0]), .ref_busy(busy[0])
  );

  sdram_init_seq #(.CLK_FREQ_MHZ(50), .T_POWERUP_US(1), .T_RFC(4)) u_dut1 (
    .clk(clk), .rst_n(rstn[1]), .cke(cke[1]), .cs_n(csn[1]), .ras_n(rasn[1]),
    .cas_n(casn[1]), .we_n(wen[1]), .addr(addr[1]), .ba(ba[1]),
    .init_done(done[1]), .ref_req(req[1]), .ref_gnt(gnt[1]), .ref_busy(busy[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", nm, k, act, exp);
    end
  endtask

  function automatic logic [3:0] cmd_of(input int s);
    return {csn[s], rasn[s], casn[s], wen[s]};
  endfunction

  function automatic logic [22:0] snap(input int s);
    return {cmd_of(s), addr[s], ba[s], cke[s], done[s], req[s], busy[s]};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One reset edge, then check the INHIBIT/reset state; rst_n is left low for the caller to release.
  task automatic do_reset(input int s);
    rstn[s] = 1'b0;
    step();
    chk("rst_cmd",  -1, 32'(cmd_of(s)), 32'(INH));
    chk("rst_cke",  -1, 32'(cke[s]), 0);
    chk("rst_addr", -1, 32'(addr[s]), 0);
    chk("rst_ba",   -1, 32'(ba[s]), 0);
    chk("rst_done", -1, 32'(done[s]), 0);
    chk("rst_req",  -1, 32'(req[s]), 0);
    chk("rst_busy", -1, 32'(busy[s]), 0);
  endtask

  // Releases reset and walks the init sequence cycle by cycle; k=0 is the first edge sampling rst_n=1.
  task automatic check_init(input int s, input int p, input int trfc, input int stop_at);
    ev_t ev[4];
    int done_c = p + 4 + 2 * trfc;
    int lim    = (stop_at < done_c) ? stop_at : done_c;
    int bad    = 0;
    logic [3:0]  ecmd;
    logic [12:0] eaddr;
    ev[0] = '{p,            PRE, 13'h0400};
    ev[1] = '{p + 2,        REF, 13'h0000};
    ev[2] = '{p + 2 + trfc, REF, 13'h0000};
    ev[3] = '{p + 2 + 2*trfc, LMR, 13'h0030};
    rstn[s] = 1'b1;
    for (int k = 0; k <= lim; k++) begin
      gnt[s] = (k % 3 == 1);
      step();
      ecmd  = NOP;
      eaddr = '0;
      for (int i = 0; i < 4; i++) begin
        if (ev[i].cyc == k) begin
          ecmd  = ev[i].cmd;
          eaddr = ev[i].addr;
          chk("init_cmd",  k, 32'(cmd_of(s)), 32'(ev[i].cmd));
          chk("init_addr", k, 32'(addr[s]), 32'(ev[i].addr));
        end
      end
      if (k == done_c - 1) chk("init_done_low",  k, 32'(done[s]), 0);
      if (k == done_c)     chk("init_done_rise", k, 32'(done[s]), 1);
      if (snap(s) !== {ecmd, eaddr, 2'b00, 1'b1, (k >= done_c), 1'b0, 1'b0}) bad++;
    end
    gnt[s] = 1'b0;
    chk("init_bad_cycles", lim, 32'(bad), 0);
  endtask

  // Continues on instance 0 from the init_done cycle (m=0): pulsed grants in READY, a 50-cycle
  // withheld grant, then grant held high.
  task automatic run_refresh(input int stop_at);
    rf_t rf[9];
    int bad = 0;
    logic ereq, ebusy;
    logic [3:0] ecmd;
    rf[0] = '{780,  1'b1, 1'b0, NOP};
    rf[1] = '{830,  1'b1, 1'b0, NOP};
    rf[2] = '{831,  1'b0, 1'b1, REF};
    rf[3] = '{837,  1'b0, 1'b1, NOP};
    rf[4] = '{838,  1'b0, 1'b0, NOP};
    rf[5] = '{1611, 1'b1, 1'b0, NOP};
    rf[6] = '{1612, 1'b0, 1'b1, REF};
    rf[7] = '{2392, 1'b1, 1'b0, NOP};
    rf[8] = '{2393, 1'b0, 1'b1, REF};
    for (int m = 1; m <= stop_at; m++) begin
      if (m < 780)       gnt[0] = (m % 5 == 0);
      else if (m <= 830) gnt[0] = 1'b0;
      else               gnt[0] = 1'b1;
      step();
      ereq  = (m >= 780 && m <= 830) || m == 1611 || m == 2392;
      ebusy = (m >= 831 && m <= 837) || (m >= 1612 && m <= 1618) || (m >= 2393 && m <= 2399);
      ecmd  = (m == 831 || m == 1612 || m == 2393) ? REF : NOP;
      for (int i = 0; i < 9; i++) begin
        if (rf[i].cyc == m) begin
          chk("ref_req",  m, 32'(req[0]),  32'(rf[i].req));
          chk("ref_busy", m, 32'(busy[0]), 32'(rf[i].busy));
          chk("ref_cmd",  m, 32'(cmd_of(0)), 32'(rf[i].cmd));
        end
      end
      if (snap(0) !== {ecmd, 13'h0, 2'b00, 1'b1, 1'b1, ereq, ebusy}) bad++;
    end
    gnt[0] = 1'b0;
    chk("ref_bad_cycles", stop_at, 32'(bad), 0);
  endtask

  initial begin
    do_reset(1);
    check_init(1, 50, 4, 1000000);
    do_reset(0);
    check_init(0, 20000, 7, 1000000);
    run_refresh(2395);
    do_reset(0);
    check_init(0, 20000, 7, 20009);
    do_reset(0);
    check_init(0, 20000, 7, 1000000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
